// File: rtl/ecall_service_unit.sv
// ecall_service_unit: services CPU ecalls (halt, LED channel writes, print stream) and captures external interrupts.
// Build macro ECALL_PRINT_FIFO_EN: defined -> FIFO_DEPTH-entry print FIFO; undefined -> single print output register.
module ecall_service_unit #(
  parameter int WIDTH      = 32,
  parameter int LED_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_IRQ    = 3,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ecall,
  input  logic [WIDTH-1:0]          r1,
  input  logic [WIDTH-1:0]          r2,
  input  logic [WIDTH-1:0]          r3,
  output logic [LED_CH*WIDTH-1:0]   led_data,
  output logic                      halt,
  output logic                      stall,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CW-1:0]             fifo_count,
  input  logic [NUM_IRQ-1:0]        irq,
  output logic                      irq_req,
  output logic [IW-1:0]             irq_id,
  input  logic                      irq_ack
);

  localparam logic [WIDTH-1:0] CODE_PRINT = WIDTH'(8'h01);
  localparam logic [WIDTH-1:0] CODE_HALT  = WIDTH'(8'h0a);
  localparam logic [WIDTH-1:0] CODE_LED   = WIDTH'(8'h22);

  logic             ecall_ok;
  logic             full;
  logic             pop;
  logic             push;
  logic             led_wr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] led [LED_CH];

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] ack_clr;

  assign pop       = out_valid & out_ready;
  assign stall     = ecall & ~halt & (r1 == CODE_PRINT) & full & ~pop;
  assign ecall_ok  = ecall & ~halt & ~stall;
  assign push      = ecall_ok & (r1 == CODE_PRINT);
  assign led_wr    = ecall_ok & (r1 == CODE_LED) & (r3 < WIDTH'(LED_CH));
  assign out_valid = (count != '0);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      halt <= 1'b0;
    end else if (ecall_ok && (r1 == CODE_HALT)) begin
      halt <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LED_CH; k++) led[k] <= '0;
    end else if (led_wr) begin
      for (int unsigned k = 0; k < LED_CH; k++) begin
        if (r3 == WIDTH'(k)) led[k] <= r2;
      end
    end
  end

  always_comb begin
    led_data = '0;
    for (int unsigned k = 0; k < LED_CH; k++) led_data[k*WIDTH +: WIDTH] = led[k];
  end

`ifdef ECALL_PRINT_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign out_data = mem[rp];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= r2;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
`else
  logic [WIDTH-1:0] hold_q;

  assign full     = (count == CW'(1));
  assign out_data = hold_q;

  always_ff @(posedge clk) begin
    if (push) hold_q <= r2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push) begin
      count <= CW'(1);
    end else if (pop) begin
      count <= '0;
    end
  end
`endif

  // irq_mask holds the levels seen during reset so a line held high across reset is not taken as an edge.
  assign irq_edge = irq & ~irq_q & ~irq_mask;
  assign irq_req  = |pending;
  assign ack_clr  = (irq_req && irq_ack) ? (NUM_IRQ'(1) << irq_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q    <= '0;
      irq_mask <= irq;
      pending  <= '0;
    end else begin
      irq_q    <= irq;
      irq_mask <= '0;
      pending  <= (pending & ~ack_clr) | irq_edge;
    end
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    irq_id = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && !found) begin
        irq_id = IW'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: doc/ecall_service_unit.md
ECALL_SERVICE_UNIT -- requirements
Module: ecall_service_unit

Interface
REQ-001 Parameter WIDTH, default 32, data width of r1/r2/r3, each LED channel and out_data.
REQ-002 Parameter LED_CH, default 4, number of LED display channels (range 1..16).
REQ-003 Parameter FIFO_DEPTH, default 4, print FIFO depth (power of two, at least 2).
REQ-004 Parameter NUM_IRQ, default 3, number of external interrupt lines (range 1..8).
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ecall  input  1  an ecall instruction is present this cycle.
REQ-008 r1  input  WIDTH  service code (a7).
REQ-009 r2  input  WIDTH  service argument (a0).
REQ-010 r3  input  WIDTH  LED channel select (a1).
REQ-011 led_data  output  LED_CH*WIDTH  LED channel registers; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 halt  output  1  registered; CPU halt request.
REQ-013 stall  output  1  combinational; the CPU holds the current ecall.
REQ-014 out_data / out_valid / out_ready  output WIDTH / output 1 / input 1  print stream with a valid/ready handshake.
REQ-015 fifo_count  output  clog2(FIFO_DEPTH)+1  current print FIFO occupancy.
REQ-016 irq  input  NUM_IRQ  level inputs from external interrupt sources.
REQ-017 irq_req / irq_id / irq_ack  output 1 / output clog2(NUM_IRQ) (minimum 1) / input 1  interrupt request, its index, and the acknowledge pulse.

Function
REQ-018 An ecall takes effect only when ecall=1, halt=0 and stall=0; in all other cases an ecall has no effect.
REQ-019 Code 0x0a sets halt in the next cycle; halt stays set until reset.
REQ-020 Code 0x22 with r3<LED_CH writes r2 to channel r3 in the next cycle; with r3>=LED_CH the ecall is ignored.
REQ-021 Code 0x01 pushes r2 into the print FIFO; all other codes have no effect.
REQ-022 stall = ecall & ~halt & (r1==0x01) & FIFO full & ~(out_valid & out_ready).
REQ-023 When the FIFO is full and a pop happens in the same cycle, a push is accepted in that cycle and stall stays 0.
REQ-024 out_valid = FIFO not empty; out_data = FIFO head; a pop occurs on out_valid & out_ready; out_data stays stable while out_valid=1 and out_ready=0.
REQ-025 A push and a pop in the same cycle leave fifo_count unchanged; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-026 A rising edge on irq[i] (detected against a registered copy of irq) sets pending[i] in the next cycle; a level held high does not set it again.
REQ-027 irq_req = |pending; irq_id = lowest set pending index, or 0 when nothing is pending.
REQ-028 irq_ack=1 clears pending[irq_id]; if a new edge arrives on that same bit in the same cycle, the set wins.
REQ-029 irq_ack with irq_req=0 has no effect.
REQ-030 Interrupt capture continues while halt=1.

Reset
REQ-031 rst clears every led_data channel, halt, the FIFO pointers, fifo_count, the pending bits and the irq edge register; rst takes priority over every other input.
REQ-032 After reset: out_valid=0, irq_req=0, irq_id=0, stall=0.
REQ-033 A reset asserted mid-stream drops any FIFO contents not yet popped.
REQ-034 An irq input held high through reset does not create a pending interrupt after reset is released.

Configuration
REQ-035 Macro ECALL_PRINT_FIFO_EN defined: the FIFO is FIFO_DEPTH entries deep, as specified in REQ-021..REQ-025.
REQ-036 ECALL_PRINT_FIFO_EN undefined: the FIFO is a single output register, so fifo_count ranges 0..1 and "full" means fifo_count=1; REQ-022..REQ-024 otherwise apply unchanged.

Verification
REQ-037 Reset, then ecall r1=0x22 r3=2 r2=0xDEADBEEF -> next cycle channel 2 = 0xDEADBEEF and all other channels = 0; repeat with r3=7 -> no channel changes.
REQ-038 Hold out_ready=0 and issue 5 print ecalls with r2=1..5 -> fifo_count reaches 4, the 5th ecall sees stall=1; raise out_ready -> outputs appear in the order 1,2,3,4,5 with no loss and no duplicates.
REQ-039 FIFO full, out_ready=1 and a print ecall in the same cycle -> stall=0 and fifo_count stays at 4.
REQ-040 Ecall 0x0a, then ecall 0x22 -> halt=1 on the next cycle and the LED channel is unchanged; pulse rst -> halt=0.
REQ-041 irq[2] and irq[0] rise in the same cycle -> irq_id=0; ack -> irq_id=2; ack -> irq_req=0; irq[2] held high -> no new request.
REQ-042 irq[1] rises on the same cycle as an ack of bit 1 -> pending[1] remains set and irq_req stays 1.
